// File: rtl/parity_frame_checker.sv
// Streaming 2-D parity checker: per-word parity plus a column-wise LRC trailer,
// reporting one status record per frame over a valid/ready handshake.
module parity_frame_checker #(
    parameter int FRAME_LEN = 8,
    parameter bit ODD       = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_par,
    input  logic        in_abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_word_err_cnt,
    output logic [15:0] out_lrc_syndrome,
    output logic        out_lrc_err,
    output logic        out_frame_ok
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_DATA   = 2'd0,
        S_TRAIL  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [15:0] r_acc;
    logic [7:0]  r_wcnt;
    logic [7:0]  r_err_cnt;
    logic [7:0]  r_st_cnt;
    logic [15:0] r_st_syn;
    logic        r_st_lrc_err;
    logic        r_st_ok;

    logic        w_xfer;
    logic        w_abort;
    logic        w_beat_err;
    logic [7:0]  w_cnt_next;
    logic [15:0] w_syn_next;

    // Shared 16-input parity reduction used for the per-word check.
    function automatic logic parity16(input logic [15:0] d);
        return ^d;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign w_xfer     = in_valid && in_ready;
    assign w_abort    = in_abort && (r_state != S_REPORT);
    assign w_beat_err = parity16(in_data) ^ in_par ^ ODD;
    assign w_cnt_next = w_beat_err ? sat_inc8(r_err_cnt) : r_err_cnt;
    assign w_syn_next = r_acc ^ in_data;

    // ---- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_DATA;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---- next-state logic; abort wins over a beat in the same cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_DATA: begin
                if (!w_abort && w_xfer && (r_wcnt == LAST_IDX)) begin
                    w_state_next = S_TRAIL;
                end
            end
            S_TRAIL: begin
                if (w_abort) begin
                    w_state_next = S_DATA;
                end else if (w_xfer) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                if (out_ready) begin
                    w_state_next = S_DATA;
                end
            end
            default: w_state_next = S_DATA;
        endcase
    end

    // ---- handshake outputs, from registered state only
    always_comb begin
        in_ready  = !rst && (r_state != S_REPORT);
        out_valid = (r_state == S_REPORT);
    end

    // ---- frame accumulation and status latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_wcnt       <= '0;
            r_err_cnt    <= '0;
            r_st_cnt     <= '0;
            r_st_syn     <= '0;
            r_st_lrc_err <= 1'b0;
            r_st_ok      <= 1'b0;
        end else if (w_abort) begin
            r_acc     <= '0;
            r_wcnt    <= '0;
            r_err_cnt <= '0;
        end else if (r_state == S_REPORT) begin
            // Status is zeroed on handshake so it reads 0 outside S_REPORT.
            if (out_ready) begin
                r_acc        <= '0;
                r_wcnt       <= '0;
                r_err_cnt    <= '0;
                r_st_cnt     <= '0;
                r_st_syn     <= '0;
                r_st_lrc_err <= 1'b0;
                r_st_ok      <= 1'b0;
            end
        end else if (w_xfer) begin
            r_acc     <= w_syn_next;
            r_err_cnt <= w_cnt_next;
            if (r_state == S_DATA && r_wcnt != LAST_IDX) begin
                r_wcnt <= r_wcnt + 8'd1;
            end
            if (r_state == S_TRAIL) begin
                r_st_cnt     <= w_cnt_next;
                r_st_syn     <= w_syn_next;
                r_st_lrc_err <= |w_syn_next;
                r_st_ok      <= (w_cnt_next == 8'd0) && (w_syn_next == 16'd0);
            end
        end
    end

    assign out_word_err_cnt = r_st_cnt;
    assign out_lrc_syndrome = r_st_syn;
    assign out_lrc_err      = r_st_lrc_err;
    assign out_frame_ok     = r_st_ok;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker with FRAME_LEN = 4, even parity.
module tb_parity_frame_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_par;
    logic        in_abort;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_word_err_cnt;
    logic [15:0] out_lrc_syndrome;
    logic        out_lrc_err;
    logic        out_frame_ok;

    int total = 0;
    int bad   = 0;

    parity_frame_checker #(.FRAME_LEN(4), .ODD(1'b0)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_par           (in_par),
        .in_abort         (in_abort),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_word_err_cnt (out_word_err_cnt),
        .out_lrc_syndrome (out_lrc_syndrome),
        .out_lrc_err      (out_lrc_err),
        .out_frame_ok     (out_frame_ok)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic v, input logic [7:0] cnt,
                                input logic [15:0] syn, input logic lrc, input logic ok);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        check({tag, ".cnt"}, 32'(out_word_err_cnt), 32'(cnt));
        check({tag, ".syn"}, 32'(out_lrc_syndrome), 32'(syn));
        check({tag, ".lrc_err"}, 32'(out_lrc_err), 32'(lrc));
        check({tag, ".frame_ok"}, 32'(out_frame_ok), 32'(ok));
    endtask

    task automatic send_beat(input string tag, input logic [15:0] d, input logic p);
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input string tag, input logic [15:0] d1, input logic p1,
                              input logic [15:0] tr, input logic tp);
        send_beat(tag, 16'h0001, 1'b1);
        send_beat(tag, 16'h0003, d1 == 16'h0003 ? p1 : 1'b0);
        send_beat(tag, 16'h00FF, 1'b0);
        send_beat(tag, 16'h8000, 1'b1);
        send_beat(tag, tr, tp);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        check({tag, ".hs_in_ready"}, 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
        check_status({tag, ".post"}, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0001;
        in_par    = 1'b0;
        in_abort  = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles with an erroneous beat on the input
        tick();
        check("rst1.in_ready", 32'(in_ready), 32'd0);
        check_status("rst1", 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0);
        tick();
        check("rst2.in_ready", 32'(in_ready), 32'd0);
        check_status("rst2", 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rel.in_ready", 32'(in_ready), 32'd1);

        // Clean frame
        send_frame("clean", 16'h0003, 1'b0, 16'h80FD, 1'b0);
        check_status("clean", 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1);
        handshake("clean");

        // Word parity error on the second beat
        send_frame("wperr", 16'h0003, 1'b1, 16'h80FD, 1'b0);
        check_status("wperr", 1'b1, 8'd1, 16'h0000, 1'b0, 1'b0);
        handshake("wperr");

        // LRC error via corrupted trailer with correct own parity
        send_frame("lrc", 16'h0003, 1'b0, 16'h80FC, 1'b1);
        check_status("lrc", 1'b1, 8'd0, 16'h0001, 1'b1, 1'b0);
        handshake("lrc");

        // Backpressure: report held while the source keeps presenting beats
        send_frame("bp", 16'h0003, 1'b0, 16'h80FD, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_par   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check_status("bp.hold", 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        handshake("bp");
        send_frame("bp2", 16'h0003, 1'b0, 16'h80FD, 1'b0);
        check_status("bp2", 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1);
        handshake("bp2");

        // Abort mid-frame with a colliding beat, then a clean frame
        send_beat("ab", 16'h0001, 1'b1);
        send_beat("ab", 16'h0003, 1'b0);
        in_abort = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_par   = 1'b1;
        tick();
        in_abort = 1'b0;
        in_valid = 1'b0;
        check("ab.no_report", 32'(out_valid), 32'd0);
        send_frame("ab2", 16'h0003, 1'b0, 16'h80FD, 1'b0);
        check_status("ab2", 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        check_status("ab2.rep_abort", 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1);
        handshake("ab2");
        tick();
        tick();
        check("ab2.single_report", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
